// File: rtl/afifo_wr_arbiter_if.sv
// Requester streams plus FIFO write port shared by the burst arbiter.
// master = arbiter side, slave = requesters/FIFO side.
interface afifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_almost_full;
    logic                    wr_en;
    logic [DATA_W-1:0]       data_in;
    logic [N_REQ-1:0]        grant;
    logic                    arb_busy;

    modport master (
        input  req_valid, req_last, req_data, fifo_full, fifo_almost_full,
        output req_ready, wr_en, data_in, grant, arb_busy
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full, fifo_almost_full,
        input  req_ready, wr_en, data_in, grant, arb_busy
    );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin burst arbiter feeding an async FIFO write port in the wr_clk domain.
// One owner per burst; writes are throttled so full/almost-full are never overrun.
module afifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic                wr_clk,
    input logic                reset,
    afifo_wr_arbiter_if.master bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    pick_idx;
    logic [7:0]          beat_cnt;
    logic [N_REQ-1:0]    grant_r;
    logic                wr_en_r;
    logic [DATA_W-1:0]   data_in_r;
    logic                pick_found;
    logic                gnt_valid;
    logic                gnt_last;
    logic                can_acc;
    logic                accept;
    logic                burst_done;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        logic [IDX_W-1:0] idx;
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        idx        = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_found && bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    assign gnt_valid  = bus.req_valid[gnt_idx];
    assign gnt_last   = bus.req_last[gnt_idx];
    // Under almost-full only one write may be in flight at a time.
    assign can_acc    = !bus.fifo_full && (!bus.fifo_almost_full || !wr_en_r);
    assign accept     = (state == BURST) && gnt_valid && can_acc;
    assign burst_done = gnt_last || (({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BURST));

    assign bus.req_ready = (reset && accept) ? grant_r : '0;
    assign bus.wr_en     = wr_en_r;
    assign bus.data_in   = data_in_r;
    assign bus.grant     = grant_r;
    assign bus.arb_busy  = (state == BURST);

    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant_r   <= '0;
            wr_en_r   <= 1'b0;
            data_in_r <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_en_r <= 1'b0;
                    if (pick_found) begin
                        state    <= BURST;
                        gnt_idx  <= pick_idx;
                        grant_r  <= N_REQ'(1) << pick_idx;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (!gnt_valid) begin
                        wr_en_r <= 1'b0;
                        state   <= IDLE;
                        grant_r <= '0;
                        rr_ptr  <= wrap_inc(gnt_idx);
                    end else if (can_acc) begin
                        wr_en_r   <= 1'b1;
                        data_in_r <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
                        beat_cnt  <= beat_cnt + 8'd1;
                        // last and MAX_BURST on the same beat collapse into one exit
                        if (burst_done) begin
                            state   <= IDLE;
                            grant_r <= '0;
                            rr_ptr  <= wrap_inc(gnt_idx);
                        end
                    end else begin
                        wr_en_r <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: directed scenarios plus randomized traffic against
// a transaction-level arbiter model and a DEPTH=8 FIFO occupancy scoreboard.
module tb_afifo_wr_arbiter;
    localparam int N = 4, DW = 32, MB = 4, DEPTH = 8;

    logic wr_clk = 1'b0;
    logic reset  = 1'b0;
    always #5 wr_clk = ~wr_clk;

    afifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();
    afifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .wr_clk(wr_clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0, failures = 0, cyc = 0;

    // requester sources: beats waiting to be offered, plus a per-requester enable
    logic [31:0] q_data[N][$];
    bit          q_last[N][$];
    bit          en[N];
    logic [N-1:0]    rv, rl;
    logic [N*DW-1:0] rd;

    // FIFO scoreboard
    bit ff_force, af_force, ffull, faf;
    int drain_pct, occ;

    // reference model: owner index (-1 = nobody), beats taken, next scan start
    int          m_owner, m_cnt, m_rr;
    bit          m_wr;
    logic [31:0] m_data;
    logic [N-1:0] m_rdy;

    // observations of the DUT outputs
    logic [31:0] obs_data[$];
    int obs_cyc[$], obs_gnt[$], gaps[$];
    int idle_run, consec;
    int wr_by[N];
    logic [N-1:0] prev_gnt;
    bit prev_wr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_rr = 0; m_wr = 1'b0; m_data = '0;
    endtask

    task automatic push(input int r, input int n, input bit last_at_end, input logic [23:0] base);
        for (int k = 0; k < n; k++) begin
            q_data[r].push_back({8'(r), base + 24'(k)});
            q_last[r].push_back(last_at_end && (k == n - 1));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            rv[i] = en[i] && (q_data[i].size() > 0);
            rl[i] = (q_data[i].size() > 0) ? q_last[i][0] : 1'b0;
            rd[i*DW +: DW] = (q_data[i].size() > 0) ? q_data[i][0] : '0;
        end
        ffull = ff_force || (occ >= DEPTH);
        faf   = af_force || (occ >= DEPTH - 2);
        bus.req_valid        = rv;
        bus.req_last         = rl;
        bus.req_data         = rd;
        bus.fifo_full        = ffull;
        bus.fifo_almost_full = faf;
    endtask

    task automatic observe();
        if (bus.wr_en) begin
            int id;
            obs_data.push_back(bus.data_in);
            obs_cyc.push_back(cyc);
            id = int'(bus.data_in[31:24]);
            if (id < N) wr_by[id]++;
            if (prev_wr) consec++;
        end
        if (bus.grant != '0 && prev_gnt == '0) begin
            obs_gnt.push_back(oh_idx(bus.grant));
            gaps.push_back(idle_run);
        end
        idle_run = (bus.grant == '0) ? idle_run + 1 : 0;
        prev_gnt = bus.grant;
        prev_wr  = bus.wr_en;
    endtask

    task automatic model_step();
        bit acc;
        if (!reset) begin
            model_reset();
            return;
        end
        acc = !ffull && (!faf || !m_wr);
        if (m_owner < 0) begin
            m_wr = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && rv[(m_rr + k) % N]) begin
                    m_owner = (m_rr + k) % N;
                    m_cnt   = 0;
                end
            end
        end else if (!rv[m_owner]) begin
            m_wr = 1'b0;
            m_rr = (m_owner + 1) % N;
            m_owner = -1;
        end else if (acc) begin
            m_wr   = 1'b1;
            m_data = rd[m_owner*DW +: DW];
            m_cnt++;
            if (rl[m_owner] || m_cnt == MB) begin
                m_rr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            m_wr = 1'b0;
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_gnt;
        int occ_n;
        bit rd_ok;
        @(negedge wr_clk);
        drive();
        #1;
        m_rdy = '0;
        if (reset && m_owner >= 0 && rv[m_owner] && !ffull && (!faf || !m_wr)) m_rdy[m_owner] = 1'b1;
        exp_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        chk("req_ready", 64'(bus.req_ready), 64'(m_rdy));
        chk("grant", 64'(bus.grant), 64'(exp_gnt));
        chk("wr_en", 64'(bus.wr_en), 64'(m_wr));
        chk("data_in", 64'(bus.data_in), 64'(m_data));
        chk("arb_busy", 64'(bus.arb_busy), 64'(m_owner >= 0));
        observe();
        @(posedge wr_clk);
        cyc++;
        rd_ok = (occ > 0) && ($urandom_range(99) < drain_pct);
        occ_n = occ - int'(rd_ok) + int'(prev_wr);
        chk("fifo_overflow", 64'(occ_n <= DEPTH), 64'(1));
        occ = (occ_n > DEPTH) ? DEPTH : occ_n;
        model_step();
        for (int i = 0; i < N; i++) begin
            if (m_rdy[i]) begin
                q_data[i].delete(0);
                q_last[i].delete(0);
            end
        end
    endtask

    task automatic clear_obs();
        obs_data.delete(); obs_cyc.delete(); obs_gnt.delete(); gaps.delete();
        idle_run = 0; consec = 0; prev_gnt = '0; prev_wr = 1'b0;
        for (int i = 0; i < N; i++) wr_by[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            q_data[i].delete(); q_last[i].delete(); en[i] = 1'b1;
        end
        ff_force = 1'b0; af_force = 1'b0; drain_pct = 100; occ = 0;
        tick();
        tick();
        #2 reset = 1'b1;
        clear_obs();
    endtask

    initial begin
        int start;
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        model_reset();
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        drain_pct = 100; occ = 0; rv = '0; rl = '0; rd = '0;
        drive();
        #1;
        chk("reset_wr_en", 64'(bus.wr_en), 64'(0));
        chk("reset_grant", 64'(bus.grant), 64'(0));
        chk("reset_data_in", 64'(bus.data_in), 64'(0));
        do_reset();

        // 1: three-beat burst from req0 into an empty FIFO
        push(0, 3, 1'b1, 24'hA00);
        start = cyc;
        for (int k = 0; k < 8; k++) tick();
        chk("t1_nwrites", 64'(obs_data.size()), 64'(3));
        chk("t1_A", 64'(obs_data[0]), 64'(32'h0000_0A00));
        chk("t1_B", 64'(obs_data[1]), 64'(32'h0000_0A01));
        chk("t1_C", 64'(obs_data[2]), 64'(32'h0000_0A02));
        chk("t1_latency", 64'(obs_cyc[0] - start), 64'(2));
        chk("t1_back2back", 64'(obs_cyc[2] - obs_cyc[0]), 64'(2));
        chk("t1_grant0", 64'(obs_gnt[0]), 64'(0));
        // pointer moved past req0: a tie between req0 and req1 goes to req1
        push(0, 1, 1'b1, 24'hB00);
        push(1, 1, 1'b1, 24'hB10);
        for (int k = 0; k < 30 && obs_gnt.size() < 2; k++) tick();
        chk("t1_rr_ptr1", 64'(obs_gnt[1]), 64'(1));

        // 2: all requesters streaming without last
        do_reset();
        for (int i = 0; i < N; i++) push(i, 20, 1'b0, 24'h200);
        for (int k = 0; k < 100 && obs_gnt.size() < 5; k++) tick();
        chk("t2_ngrants", 64'(obs_gnt.size()), 64'(5));
        for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), 64'(obs_gnt[k]), 64'(exp_ord[k]));
        for (int k = 1; k < 5; k++) chk($sformatf("t2_gap%0d", k), 64'(gaps[k]), 64'(1));
        for (int i = 0; i < N; i++) chk($sformatf("t2_writes%0d", i), 64'(wr_by[i]), 64'(MB));

        // 3: full stall after beat 2
        do_reset();
        push(0, 4, 1'b1, 24'h300);
        for (int k = 0; k < 20 && q_data[0].size() != 2; k++) tick();
        chk("t3_two_taken", 64'(q_data[0].size()), 64'(2));
        ff_force = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("t3_stall_ready", 64'(bus.req_ready), 64'(0));
            chk("t3_stall_grant", 64'(bus.grant), 64'(4'b0001));
            if (s > 0) chk("t3_stall_wr_en", 64'(bus.wr_en), 64'(0));
        end
        ff_force = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("t3_nwrites", 64'(obs_data.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk($sformatf("t3_beat%0d", k), 64'(obs_data[k]), 64'(32'h0000_0300 + k));

        // 4: almost-full held high, slow drain
        do_reset();
        af_force = 1'b1;
        drain_pct = 20;
        push(1, 60, 1'b0, 24'h400);
        for (int k = 0; k < 60; k++) tick();
        chk("t4_no_consecutive", 64'(consec), 64'(0));
        chk("t4_progress", 64'(obs_data.size() >= 8), 64'(1));

        // 5: asynchronous reset in the middle of a req2 burst
        do_reset();
        push(2, 8, 1'b0, 24'h500);
        for (int k = 0; k < 20 && q_data[2].size() != 6; k++) tick();
        chk("t5_two_taken", 64'(q_data[2].size()), 64'(6));
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("t5_async_wr_en", 64'(bus.wr_en), 64'(0));
        chk("t5_async_grant", 64'(bus.grant), 64'(0));
        chk("t5_async_ready", 64'(bus.req_ready), 64'(0));
        tick();
        tick();
        push(0, 2, 1'b1, 24'h510);
        #2 reset = 1'b1;
        clear_obs();
        for (int k = 0; k < 6; k++) tick();
        chk("t5_first_grant", 64'(obs_gnt[0]), 64'(0));

        // 6: granted req3 abandons after one beat while req0 waits
        do_reset();
        push(3, 3, 1'b0, 24'h600);
        for (int k = 0; k < 10 && obs_gnt.size() < 1; k++) tick();
        chk("t6_grant3", 64'(obs_gnt[0]), 64'(3));
        push(0, 3, 1'b1, 24'h610);
        for (int k = 0; k < 10 && q_data[3].size() != 2; k++) tick();
        en[3] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("t6_next_grant", 64'(obs_gnt[1]), 64'(0));
        chk("t6_idle_gap", 64'(gaps[1]), 64'(1));
        chk("t6_req3_writes", 64'(wr_by[3]), 64'(1));

        // randomized traffic, abandons, full pulses and FIFO back-pressure
        do_reset();
        drain_pct = 60;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(99) < 15 && q_data[i].size() < 16) begin
                    q_data[i].push_back({8'(i), 24'($urandom)});
                    q_last[i].push_back($urandom_range(3) == 0);
                end
                en[i] = ($urandom_range(99) >= 5);
            end
            ff_force = ($urandom_range(99) < 5);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
